// File: rtl/core_ctrl.sv
// ---------------------------------------------------------------------------
// core_ctrl -- multi-cycle control sequencer for the 8-bit lab core.
//
// Owns the program counter and walks every instruction through four phases
// (FETCH, DECODE, EXEC, WB). Branch redirection comes from the alu: the
// target and the taken decision are captured in EXEC and applied in WB.
// A sticky overflow flag and a retired-instruction counter are kept for
// observation.
//
// Ports:
//   clk             core clock, rising edge
//   rst_n           asynchronous active-low reset
//   start_i         start pulse, honoured only in IDLE or HALT
//   start_addr_i    first PC value loaded on start
//   imem_addr_o     instruction ROM address (ROM data valid one cycle later)
//   instr_i         instruction word {opcode[8:5], rs1/rd[4:2], rs2/const[1:0]}
//   opcode_o        opcode to the alu
//   rs1_sel_o       register-file port A select / write select
//   rs2_sel_o       register-file port B select
//   const_o         constant to the alu (same bits as rs2_sel_o)
//   branch_taken_i  branch decision from the alu
//   alu_out_i       alu result; branch target for beq0 and jmp
//   overflow_i      alu overflow
//   reg_we_o        register-file write enable, one-cycle pulse in WB
//   busy_o          high while an instruction is in flight
//   done_o          high in HALT
//   ovf_flag_o      sticky overflow flag (set by add, cleared on start)
//   retired_o       number of instructions that completed WB
// ---------------------------------------------------------------------------
module core_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  start_addr_i,
    output logic [7:0]  imem_addr_o,
    input  logic [8:0]  instr_i,
    output logic [3:0]  opcode_o,
    output logic [2:0]  rs1_sel_o,
    output logic [1:0]  rs2_sel_o,
    output logic [1:0]  const_o,
    input  logic        branch_taken_i,
    input  logic [7:0]  alu_out_i,
    input  logic        overflow_i,
    output logic        reg_we_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovf_flag_o,
    output logic [15:0] retired_o
);

    localparam logic [3:0] HALT_OP = 4'b1110;
    localparam logic [3:0] ADD_OP  = 4'b0000;
    localparam logic [8:0] NOP_IR  = 9'h1E0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [8:0]  ir_q, ir_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        taken_q, taken_d;
    logic        ovf_q, ovf_d;
    logic [15:0] retired_q, retired_d;

    logic [3:0]  op;
    logic        op_writes;

    assign op = ir_q[8:5];

    // Opcodes that do not write the register file: beq0, jmp, reserved, nop.
    // HALT never reaches WB, so its value here does not matter.
    always_comb begin
        case (op)
            4'b0101, 4'b1011, 4'b1101, 4'b1110, 4'b1111: op_writes = 1'b0;
            default:                                     op_writes = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        tgt_d     = tgt_q;
        taken_d   = taken_q;
        ovf_d     = ovf_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    pc_d      = start_addr_i;
                    ovf_d     = 1'b0;
                    retired_d = 16'd0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // ROM output registered from the FETCH address is valid now.
                ir_d    = instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                tgt_d   = alu_out_i;
                taken_d = branch_taken_i;
                state_d = (op == HALT_OP) ? S_HALT : S_WB;
            end
            S_WB: begin
                pc_d      = taken_q ? tgt_q : pc_q + 8'd1;
                retired_d = retired_q + 16'd1;
                if (op == ADD_OP && overflow_i) begin
                    ovf_d = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            ir_q      <= NOP_IR;
            tgt_q     <= 8'h00;
            taken_q   <= 1'b0;
            ovf_q     <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            tgt_q     <= tgt_d;
            taken_q   <= taken_d;
            ovf_q     <= ovf_d;
            retired_q <= retired_d;
        end
    end

    // The ir only changes in DECODE, so the alu operands stay stable from
    // EXEC through WB and the write-back data is valid under reg_we_o.
    assign imem_addr_o = pc_q;
    assign opcode_o    = ir_q[8:5];
    assign rs1_sel_o   = ir_q[4:2];
    assign rs2_sel_o   = ir_q[1:0];
    assign const_o     = ir_q[1:0];
    assign reg_we_o    = (state_q == S_WB) && op_writes;
    assign busy_o      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
    assign done_o      = (state_q == S_HALT);
    assign ovf_flag_o  = ovf_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_core_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl -- self-checking bench for core_ctrl.
// A registered instruction ROM and a table-driven alu stub surround the DUT.
// The reference model walks the program at instruction level (pc, retire
// count, overflow flag) and predicts the four-cycle phase outputs.
// ---------------------------------------------------------------------------
module tb_core_ctrl;

    localparam logic [7:0] START_DEFAULT = 8'h00;
    localparam logic [3:0] HALT_OP       = 4'b1110;
    localparam logic [8:0] HALT_W        = 9'h1C0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  start_addr_i = START_DEFAULT;
    logic [7:0]  imem_addr_o;
    logic [8:0]  instr_i = 9'h000;
    logic [3:0]  opcode_o;
    logic [2:0]  rs1_sel_o;
    logic [1:0]  rs2_sel_o;
    logic [1:0]  const_o;
    logic        branch_taken_i;
    logic [7:0]  alu_out_i;
    logic        overflow_i;
    logic        reg_we_o;
    logic        busy_o;
    logic        done_o;
    logic        ovf_flag_o;
    logic [15:0] retired_o;

    logic [8:0] rom   [256];
    logic [7:0] alu_t [512];
    bit         tk_t  [512];
    bit         ov_t  [512];
    logic [8:0] stub_w;

    int n_chk  = 0;
    int n_pass = 0;

    core_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .start_addr_i   (start_addr_i),
        .imem_addr_o    (imem_addr_o),
        .instr_i        (instr_i),
        .opcode_o       (opcode_o),
        .rs1_sel_o      (rs1_sel_o),
        .rs2_sel_o      (rs2_sel_o),
        .const_o        (const_o),
        .branch_taken_i (branch_taken_i),
        .alu_out_i      (alu_out_i),
        .overflow_i     (overflow_i),
        .reg_we_o       (reg_we_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ovf_flag_o     (ovf_flag_o),
        .retired_o      (retired_o)
    );

    always #5 clk = ~clk;

    // Registered instruction ROM.
    always @(posedge clk) instr_i <= rom[imem_addr_o];

    // alu stub: a combinational function of the operands it is given.
    always_comb begin
        stub_w         = {opcode_o, rs1_sel_o, rs2_sel_o};
        alu_out_i      = alu_t[stub_w];
        branch_taken_i = tk_t[stub_w];
        overflow_i     = ov_t[stub_w];
    end

    task automatic init_tables();
        logic [8:0] w;
        for (int i = 0; i < 512; i++) begin
            w        = 9'(i);
            alu_t[i] = 8'($urandom);
            tk_t[i]  = (w[8:5] == 4'b1011) ? 1'b1 :
                       (w[8:5] == 4'b0101) ? 1'($urandom) : 1'b0;
            ov_t[i]  = 1'($urandom);
        end
    endtask

    task automatic fill_rom(input bit allow_halt);
        logic [8:0] w;
        for (int a = 0; a < 256; a++) begin
            w = 9'($urandom);
            if (!allow_halt && w[8:5] == HALT_OP) w[8:5] = 4'b0001;
            rom[a] = w;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Starts the program at sa and checks every phase of up to max_instr
    // instructions. mid_k: pulse start_i in EXEC of that instruction.
    // rst_k: pull rst_n low during WB of that instruction.
    task automatic run_prog(input logic [7:0] sa, input int max_instr,
                            input int mid_k, input int rst_k,
                            output int we_cnt, output bit halted);
        logic [7:0]  m_pc;
        bit          m_ovf;
        logic [15:0] m_ret;
        logic [8:0]  w;
        logic [3:0]  op;
        bit          exp_we;
        we_cnt = 0; halted = 1'b0;
        m_pc = sa; m_ovf = 1'b0; m_ret = 16'd0;
        start_addr_i = sa; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        for (int k = 0; k < max_instr; k++) begin
            n_chk++;
            if ({imem_addr_o, busy_o, done_o, reg_we_o, ovf_flag_o, retired_o} !==
                {m_pc, 1'b1, 1'b0, 1'b0, m_ovf, m_ret})
                $display("FAIL fetch k=%0d got addr=%h busy=%b done=%b we=%b ovf=%b ret=%0d want addr=%h busy=1 done=0 we=0 ovf=%b ret=%0d",
                         k, imem_addr_o, busy_o, done_o, reg_we_o, ovf_flag_o, retired_o, m_pc, m_ovf, m_ret);
            else n_pass++;
            w = rom[m_pc]; op = w[8:5];
            @(posedge clk); #1;   // DECODE
            @(posedge clk); #1;   // EXEC
            n_chk++;
            if ({opcode_o, rs1_sel_o, rs2_sel_o, const_o, reg_we_o, busy_o} !==
                {op, w[4:2], w[1:0], w[1:0], 1'b0, 1'b1})
                $display("FAIL exec k=%0d got op=%h rs1=%0d rs2=%0d c=%0d we=%b busy=%b want op=%h rs1=%0d rs2=%0d we=0 busy=1",
                         k, opcode_o, rs1_sel_o, rs2_sel_o, const_o, reg_we_o, busy_o, op, w[4:2], w[1:0]);
            else n_pass++;
            if (k == mid_k) start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            if (op == HALT_OP) begin
                n_chk++;
                if ({done_o, busy_o, reg_we_o, imem_addr_o, retired_o, ovf_flag_o} !==
                    {1'b1, 1'b0, 1'b0, m_pc, m_ret, m_ovf})
                    $display("FAIL halt got done=%b busy=%b we=%b addr=%h ret=%0d ovf=%b want done=1 busy=0 we=0 addr=%h ret=%0d ovf=%b",
                             done_o, busy_o, reg_we_o, imem_addr_o, retired_o, ovf_flag_o, m_pc, m_ret, m_ovf);
                else n_pass++;
                $display("instr k=%0d pc=%h word=%h HALT retired=%0d", k, m_pc, w, m_ret);
                halted = 1'b1;
                return;
            end
            exp_we = !(op inside {4'b0101, 4'b1011, 4'b1101, 4'b1111});
            n_chk++;
            if ({reg_we_o, busy_o, done_o} !== {exp_we, 1'b1, 1'b0})
                $display("FAIL wb k=%0d op=%h got we=%b busy=%b done=%b want we=%b busy=1 done=0",
                         k, op, reg_we_o, busy_o, done_o, exp_we);
            else n_pass++;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                n_chk++;
                if ({reg_we_o, busy_o, done_o, imem_addr_o, opcode_o, retired_o, ovf_flag_o} !==
                    {1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 16'h0000, 1'b0})
                    $display("FAIL rst_in_wb got we=%b busy=%b done=%b addr=%h op=%h ret=%0d ovf=%b want all reset values",
                             reg_we_o, busy_o, done_o, imem_addr_o, opcode_o, retired_o, ovf_flag_o);
                else n_pass++;
                $display("instr k=%0d pc=%h word=%h reset during WB", k, m_pc, w);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (op == 4'b0000 && ov_t[w]) m_ovf = 1'b1;
            m_ret  = m_ret + 16'd1;
            we_cnt = we_cnt + int'(exp_we);
            $display("instr k=%0d pc=%h word=%h we=%b taken=%b next=%h", k, m_pc, w, exp_we, tk_t[w],
                     tk_t[w] ? alu_t[w] : m_pc + 8'd1);
            m_pc = tk_t[w] ? alu_t[w] : m_pc + 8'd1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if ({imem_addr_o, opcode_o, rs1_sel_o, rs2_sel_o, const_o, reg_we_o, busy_o, done_o, ovf_flag_o, retired_o} !==
                {8'h00, 4'hF, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000})
                $display("FAIL reset_idle c=%0d got addr=%h op=%h rs1=%0d rs2=%0d we=%b busy=%b done=%b ovf=%b ret=%0d want reset values",
                         c, imem_addr_o, opcode_o, rs1_sel_o, rs2_sel_o, reg_we_o, busy_o, done_o, ovf_flag_o, retired_o);
            else n_pass++;
            $display("reset idle cycle %0d", c);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_straight_line();
        int we; bit h;
        rom[0] = 9'b0110_001_00; rom[1] = 9'b0111_001_01;
        rom[2] = 9'b0111_001_01; rom[3] = HALT_W;
        tk_t[rom[0]] = 1'b0; tk_t[rom[1]] = 1'b0;
        run_prog(8'h00, 8, -1, -1, we, h);
        n_chk++;
        if ({h, we, retired_o} !== {1'b1, 32'd3, 16'd3})
            $display("FAIL straight_line got halted=%b we_pulses=%0d retired=%0d want 1 3 3", h, we, retired_o);
        else n_pass++;
    endtask

    task automatic test_jmp();
        int we; bit h;
        rom[5] = 9'b1011_000_00; alu_t[rom[5]] = 8'h0B; tk_t[rom[5]] = 1'b1;
        rom[8'h0B] = HALT_W;
        run_prog(8'h05, 4, -1, -1, we, h);
        n_chk++;
        if ({h, we, retired_o, imem_addr_o} !== {1'b1, 32'd0, 16'd1, 8'h0B})
            $display("FAIL jmp got halted=%b we_pulses=%0d retired=%0d addr=%h want 1 0 1 0b", h, we, retired_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_beq0_not_taken();
        int we; bit h;
        rom[8'h20] = 9'b0101_010_01; alu_t[rom[8'h20]] = 8'h16; tk_t[rom[8'h20]] = 1'b0;
        rom[8'h21] = HALT_W;
        run_prog(8'h20, 4, -1, -1, we, h);
        n_chk++;
        if ({h, we, retired_o, imem_addr_o} !== {1'b1, 32'd0, 16'd1, 8'h21})
            $display("FAIL beq0 got halted=%b we_pulses=%0d retired=%0d addr=%h want 1 0 1 21", h, we, retired_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_overflow_wrap();
        int we; bit h;
        rom[8'hFF] = 9'b0000_001_10; ov_t[rom[8'hFF]] = 1'b1; tk_t[rom[8'hFF]] = 1'b0;
        rom[8'h00] = 9'b0000_001_11; ov_t[rom[8'h00]] = 1'b0; tk_t[rom[8'h00]] = 1'b0;
        rom[8'h01] = HALT_W;
        run_prog(8'hFF, 4, -1, -1, we, h);
        n_chk++;
        if ({h, ovf_flag_o, retired_o, imem_addr_o} !== {1'b1, 1'b1, 16'd2, 8'h01})
            $display("FAIL ovf_wrap got halted=%b ovf=%b retired=%0d addr=%h want 1 1 2 01", h, ovf_flag_o, retired_o, imem_addr_o);
        else n_pass++;
        // Restart straight from HALT: flag and counter clear.
        run_prog(8'h01, 2, -1, -1, we, h);
        n_chk++;
        if ({h, ovf_flag_o, retired_o} !== {1'b1, 1'b0, 16'd0})
            $display("FAIL ovf_restart got halted=%b ovf=%b retired=%0d want 1 0 0", h, ovf_flag_o, retired_o);
        else n_pass++;
    endtask

    task automatic test_mid_run();
        int we; bit h;
        fill_rom(1'b0);
        // start_i pulsed in EXEC of instruction 1 must not disturb the run;
        // reset during WB of instruction 3 drops everything.
        run_prog(8'($urandom), 6, 1, 3, we, h);
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if ({busy_o, done_o, reg_we_o, retired_o, imem_addr_o} !== {1'b0, 1'b0, 1'b0, 16'd0, 8'h00})
                $display("FAIL post_reset c=%0d got busy=%b done=%b we=%b ret=%0d addr=%h want 0 0 0 0 00",
                         c, busy_o, done_o, reg_we_o, retired_o, imem_addr_o);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int we; bit h;
        for (int r = 0; r < 5; r++) begin
            fill_rom(1'b1);
            run_prog(8'($urandom), 20, -1, -1, we, h);
            if (h) run_prog(8'($urandom), 8, -1, -1, we, h);   // back-to-back restart from HALT
            do_reset();
        end
    endtask

    initial begin
        init_tables();
        fill_rom(1'b1);
        test_reset();
        test_straight_line();
        test_jmp();
        test_beq0_not_taken();
        test_overflow_wrap();
        do_reset();
        test_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
